// File: rtl/key_event_fsm.sv
// key_event_fsm
// Classifies a debounced, active-low key into one-cycle gesture pulses:
// single click, double click, long press and auto-repeat while a long press
// is held. A running 8-bit count of every pulse emitted is also kept.
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   key_in    in   debounced key level, 0 = pressed
//   single_o  out  one-cycle pulse, single click
//   double_o  out  one-cycle pulse, double click
//   long_o    out  one-cycle pulse, long-press threshold reached
//   repeat_o  out  one-cycle pulse, periodic repeat while a long press is held
//   busy_o    out  high while a gesture is in progress
//   evt_cnt   out  running count of emitted pulses, wraps 255 -> 0
module key_event_fsm #(
  parameter int unsigned LONG_CYC   = 50_000_000,
  parameter int unsigned GAP_CYC    = 12_500_000,
  parameter int unsigned REPEAT_CYC = 10_000_000,
  parameter int unsigned CNT_W      = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       single_o,
  output logic       double_o,
  output logic       long_o,
  output logic       repeat_o,
  output logic       busy_o,
  output logic [7:0] evt_cnt
);

  localparam logic [2:0] ARM       = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] PRESS1    = 3'd2;
  localparam logic [2:0] WAIT2     = 3'd3;
  localparam logic [2:0] PRESS2    = 3'd4;
  localparam logic [2:0] LONG_HOLD = 3'd5;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

  logic             key_q;       // 1 = pressed
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             single_q, single_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             busy_q, busy_d;
  logic [7:0]       evt_q, evt_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    unique case (state_q)
      // Leaves ARM only once the key is seen released, so a key held through
      // reset cannot start a gesture.
      ARM: begin
        if (!key_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (key_q) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      PRESS1: begin
        if (!key_q) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG_HOLD;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Release after a long press is silent; otherwise repeat periodically.
      LONG_HOLD: begin
        if (!key_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // A press landing on the timeout cycle still wins and becomes PRESS2.
      WAIT2: begin
        if (key_q) begin
          state_d = PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d  = IDLE;
          cnt_d    = '0;
          single_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Untimed: the second press may be held indefinitely.
      PRESS2: begin
        if (!key_q) begin
          state_d  = IDLE;
          cnt_d    = '0;
          double_d = 1'b1;
        end
      end
      default: begin
        state_d = ARM;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy_d = (state_d == PRESS1) || (state_d == WAIT2) ||
             (state_d == PRESS2) || (state_d == LONG_HOLD);
    // Pulses are mutually exclusive, so a single increment covers any of them.
    evt_d  = evt_q + 8'(single_d | double_d | long_d | repeat_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q    <= 1'b1;
      state_q  <= ARM;
      cnt_q    <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
      evt_q    <= '0;
    end else begin
      key_q    <= ~key_in;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      busy_q   <= busy_d;
      evt_q    <= evt_d;
    end
  end

  assign single_o = single_q;
  assign double_o = double_q;
  assign long_o   = long_q;
  assign repeat_o = repeat_q;
  assign busy_o   = busy_q;
  assign evt_cnt  = evt_q;

endmodule

// File: tb/tb_key_event_fsm.sv
// Directed bench for key_event_fsm with short timing parameters
// (LONG=20, GAP=8, REPEAT=5). Each step drives key_in for one edge; outputs
// are sampled on the falling edge. Pulse edge numbers are predicted by hand
// from the key_in edge on which a press/release is first sampled.
module tb_key_event_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_in = 1'b1;
  logic       single_o, double_o, long_o, repeat_o, busy_o;
  logic [7:0] evt_cnt;

  key_event_fsm #(
    .LONG_CYC(20), .GAP_CYC(8), .REPEAT_CYC(5), .CNT_W(6)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .single_o(single_o), .double_o(double_o), .long_o(long_o),
    .repeat_o(repeat_o), .busy_o(busy_o), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Pulse recorder: counts every high cycle so a wide pulse shows up as >1.
  int n_single = 0, n_double = 0, n_long = 0, n_rep = 0, busy_rise = 0;
  int e_single = -1, e_double = -1, e_long = -1, e_rep_first = -1, e_rep_last = -1;
  int n_multi = 0, n_evt_bad = 0;
  logic       busy_prev = 1'b0;
  logic [7:0] evt_prev = 8'd0;
  always @(negedge clk) begin
    if (int'(single_o) + int'(double_o) + int'(long_o) + int'(repeat_o) > 1) n_multi++;
    if ((single_o | double_o | long_o | repeat_o) && (evt_cnt !== 8'(evt_prev + 8'd1)))
      n_evt_bad++;
    if (single_o) begin n_single++; e_single = edge_n; end
    if (double_o) begin n_double++; e_double = edge_n; end
    if (long_o)   begin n_long++;   e_long   = edge_n; end
    if (repeat_o) begin
      if (e_rep_first < 0) e_rep_first = edge_n;
      n_rep++; e_rep_last = edge_n;
    end
    if (busy_o && !busy_prev) busy_rise++;
    busy_prev = busy_o;
    evt_prev  = evt_cnt;
  end

  int errors = 0, checks = 0;
  int b_single, b_double, b_long, b_rep, b_busy;
  int p;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic k, input int n);
    repeat (n) begin
      key_in = k;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic snap();
    b_single = n_single; b_double = n_double; b_long = n_long;
    b_rep = n_rep; b_busy = busy_rise;
    e_rep_first = -1;
  endtask

  initial begin
    @(negedge clk);
    cyc(1'b1, 3);
    chk("rst_single", int'(single_o), 0);
    chk("rst_busy",   int'(busy_o), 0);
    chk("rst_evt",    int'(evt_cnt), 0);
    rst = 1'b0;
    cyc(1'b1, 3);

    // 1: single click
    snap();
    cyc(1'b0, 1); p = edge_n; cyc(1'b0, 2);
    chk("t1_busy_mid", int'(busy_o), 1);
    cyc(1'b1, 15);
    chk("t1_single_n",    n_single - b_single, 1);
    chk("t1_single_edge", e_single, p + 12);
    chk("t1_double_n",    n_double - b_double, 0);
    chk("t1_evt",         int'(evt_cnt), 1);
    chk("t1_busy_after",  int'(busy_o), 0);

    // 2: double click; pulse lands on the edge after the release is registered
    snap();
    cyc(1'b0, 1); p = edge_n; cyc(1'b0, 2);
    cyc(1'b1, 4); cyc(1'b0, 3); cyc(1'b1, 15);
    chk("t2_double_n",    n_double - b_double, 1);
    chk("t2_double_edge", e_double, p + 11);
    chk("t2_single_n",    n_single - b_single, 0);
    chk("t2_evt",         int'(evt_cnt), 2);

    // 3: long hold of 40 edges, then release
    snap();
    cyc(1'b0, 1); p = edge_n; cyc(1'b0, 39); cyc(1'b1, 15);
    chk("t3_long_n",     n_long - b_long, 1);
    chk("t3_long_edge",  e_long, p + 21);
    chk("t3_rep_n",      n_rep - b_rep, 3);
    chk("t3_rep_first",  e_rep_first, p + 26);
    chk("t3_rep_last",   e_rep_last, p + 36);
    chk("t3_single_n",   n_single - b_single, 0);
    chk("t3_double_n",   n_double - b_double, 0);
    chk("t3_evt",        int'(evt_cnt), 6);
    chk("t3_busy_after", int'(busy_o), 0);

    // 4a: 7-edge gap -> second press is PRESS2
    snap();
    cyc(1'b0, 1); p = edge_n; cyc(1'b0, 2);
    cyc(1'b1, 7); cyc(1'b0, 3); cyc(1'b1, 15);
    chk("t4a_single_n",    n_single - b_single, 0);
    chk("t4a_double_n",    n_double - b_double, 1);
    chk("t4a_double_edge", e_double, p + 14);
    chk("t4a_evt",         int'(evt_cnt), 7);

    // 4b: 8-edge gap -> press arrives on the timeout cycle and still wins
    snap();
    cyc(1'b0, 1); p = edge_n; cyc(1'b0, 2);
    cyc(1'b1, 8); cyc(1'b0, 3); cyc(1'b1, 15);
    chk("t4b_single_n",    n_single - b_single, 0);
    chk("t4b_double_n",    n_double - b_double, 1);
    chk("t4b_double_edge", e_double, p + 15);
    chk("t4b_evt",         int'(evt_cnt), 8);

    // 4c: 9-edge gap -> single fires, next press is a fresh PRESS1
    snap();
    cyc(1'b0, 1); p = edge_n; cyc(1'b0, 2);
    cyc(1'b1, 9); cyc(1'b0, 1);
    chk("t4c_single_now", int'(single_o), 1);
    cyc(1'b0, 2); cyc(1'b1, 15);
    chk("t4c_single_n",    n_single - b_single, 2);
    chk("t4c_single_edge", e_single, p + 24);
    chk("t4c_double_n",    n_double - b_double, 0);
    chk("t4c_evt",         int'(evt_cnt), 10);

    // 5: reset mid-PRESS1 with key held through and after reset
    snap();
    cyc(1'b0, 6);
    rst = 1'b1; cyc(1'b0, 1); rst = 1'b0;
    chk("t5_evt_rst",  int'(evt_cnt), 0);
    chk("t5_busy_rst", int'(busy_o), 0);
    cyc(1'b0, 30);
    chk("t5_long_n",   n_long - b_long, 0);
    chk("t5_single_n", n_single - b_single, 0);
    chk("t5_busy_hold", int'(busy_o), 0);
    chk("t5_evt_hold", int'(evt_cnt), 0);
    cyc(1'b1, 4);
    cyc(1'b0, 1); p = edge_n; cyc(1'b0, 2); cyc(1'b1, 15);
    chk("t5_single_after", n_single - b_single, 1);
    chk("t5_single_edge",  e_single, p + 12);
    chk("t5_evt_after",    int'(evt_cnt), 1);

    // 6: 256 singles wrap evt_cnt back to 0
    rst = 1'b1; cyc(1'b1, 1); rst = 1'b0; cyc(1'b1, 3);
    chk("t6_evt_start", int'(evt_cnt), 0);
    snap();
    for (int i = 0; i < 256; i++) begin
      cyc(1'b0, 3); cyc(1'b1, 12);
      if (i == 254) chk("t6_evt_255", int'(evt_cnt), 255);
    end
    chk("t6_single_n", n_single - b_single, 256);
    chk("t6_busy_rise", busy_rise - b_busy, 256);
    chk("t6_evt_wrap", int'(evt_cnt), 0);
    chk("t6_busy_end", int'(busy_o), 0);

    chk("onehot_pulses", n_multi, 0);
    chk("evt_step",      n_evt_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
